pio_filter_bridge: RTL



---
 rtl/pio_filter_pkg.sv | 40 ++++
 rtl/filter_channel.sv | 74 +++++++
 rtl/pio_filter_bridge.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pio_filter_pkg.sv
// Shared types, field positions and size helpers for the PIO filter bridge.
// Used by the bridge top level and its per-channel filter datapath.
package pio_filter_pkg;

   typedef enum logic [1:0] {
      OP_WRITE   = 2'b00,
      OP_READ    = 2'b01,
      OP_CLEAR   = 2'b10,
      OP_SETMODE = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      MODE_AVG    = 2'b00,
      MODE_BYPASS = 2'b01,
      MODE_PEAK   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SCAN,
      ST_RESP
   } state_e;

   localparam int IN_REQ   = 31;
   localparam int IN_OP_HI = 30;
   localparam int IN_OP_LO = 29;
   localparam int IN_CH_HI = 27;
   localparam int IN_CH_LO = 24;

   localparam int OUT_ACK  = 15;
   localparam int OUT_BUSY = 14;
   localparam int OUT_ERR  = 13;

   function automatic int log2_taps(input int taps);
      return $clog2(taps);
   endfunction

endpackage

// File: rtl/filter_channel.sv
// One sliding-window channel: circular sample buffer, running sum, last sample, mode.
// Updates land one cycle after the enable; the indexed read port is combinational.
module filter_channel
   import pio_filter_pkg::*;
#(
   parameter  int DATA_W    = 12,
   parameter  int TAPS      = 8,
   localparam int LOG2_TAPS = log2_taps(TAPS),
   localparam int SUM_W     = DATA_W + LOG2_TAPS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 clr_en,
   input  logic                 mode_en,
   input  logic [DATA_W-1:0]    din,
   input  logic [1:0]           mode_in,
   input  logic [LOG2_TAPS-1:0] rd_idx,
   output logic [DATA_W-1:0]    rd_dat,
   output logic [SUM_W-1:0]     sum,
   output logic [DATA_W-1:0]    last,
   output mode_e                mode
);

   logic [DATA_W-1:0]    smp_q [TAPS];
   logic [DATA_W-1:0]    smp_d [TAPS];
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [LOG2_TAPS-1:0] wptr_q, wptr_d;
   logic [DATA_W-1:0]    last_q, last_d;
   mode_e                mode_q, mode_d;

   always_comb begin
      smp_d  = smp_q;
      sum_d  = sum_q;
      wptr_d = wptr_q;
      last_d = last_q;
      mode_d = mode_q;
      if (clr_en) begin
         for (int i = 0; i < TAPS; i++) smp_d[i] = '0;
         sum_d  = '0;
         wptr_d = '0;
         last_d = '0;
      end else if (wr_en) begin
         // The oldest sample leaves the window as the new one enters, so the sum stays exact.
         smp_d[wptr_q] = din;
         sum_d  = sum_q - SUM_W'(smp_q[wptr_q]) + SUM_W'(din);
         last_d = din;
         wptr_d = wptr_q + LOG2_TAPS'(1);
      end
      if (mode_en) mode_d = mode_e'(mode_in);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) smp_q[i] <= '0;
         sum_q  <= '0;
         wptr_q <= '0;
         last_q <= '0;
         mode_q <= MODE_AVG;
      end else begin
         smp_q  <= smp_d;
         sum_q  <= sum_d;
         wptr_q <= wptr_d;
         last_q <= last_d;
         mode_q <= mode_d;
      end
   end

   assign rd_dat = smp_q[rd_idx];
   assign sum    = sum_q;
   assign last   = last_q;
   assign mode   = mode_q;

endmodule

// File: rtl/pio_filter_bridge.sv
// HPS PIO bridge to NUM_CH filter channels over a toggle req/ack handshake.
// Ack lands 3 cycles after detect (3+TAPS for peak reads); new toggles wait until IDLE.
module pio_filter_bridge
   import pio_filter_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int NUM_CH = 4,
   parameter int TAPS   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inp,
   output logic [15:0] outp
);

   localparam int LOG2_TAPS = log2_taps(TAPS);
   localparam int SUM_W     = DATA_W + LOG2_TAPS;

   logic [31:0]          s1_q, s1_d, s2_q, s2_d;
   state_e               state_q, state_d;
   logic                 req_seen_q, req_seen_d;
   op_e                  op_q, op_d;
   logic [3:0]           ch_q, ch_d;
   logic [DATA_W-1:0]    pay_q, pay_d;
   logic [1:0]           msel_q, msel_d;
   logic [LOG2_TAPS-1:0] idx_q, idx_d;
   logic [DATA_W-1:0]    max_q, max_d;
   logic                 ack_q, ack_d, busy_q, busy_d, err_q, err_d;
   logic [DATA_W-1:0]    res_q, res_d;

   logic [NUM_CH-1:0]    wr_vec, clr_vec, mode_vec;
   logic [DATA_W-1:0]    rd_a [NUM_CH];
   logic [SUM_W-1:0]     sum_a [NUM_CH];
   logic [DATA_W-1:0]    last_a [NUM_CH];
   mode_e                mode_a [NUM_CH];

   logic [DATA_W-1:0]    sel_rd, sel_last;
   logic [SUM_W-1:0]     sel_sum;
   mode_e                sel_mode;
   logic                 bad;
   logic                 unused_bits;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      filter_channel #(.DATA_W(DATA_W), .TAPS(TAPS)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_vec[g]),
         .clr_en  (clr_vec[g]),
         .mode_en (mode_vec[g]),
         .din     (pay_q),
         .mode_in (msel_q),
         .rd_idx  (idx_q),
         .rd_dat  (rd_a[g]),
         .sum     (sum_a[g]),
         .last    (last_a[g]),
         .mode    (mode_a[g])
      );
   end

   assign bad = (int'(ch_q) >= NUM_CH) || (op_q == OP_SETMODE && msel_q == 2'b11);

   always_comb begin
      sel_rd   = '0;
      sel_sum  = '0;
      sel_last = '0;
      sel_mode = MODE_AVG;
      wr_vec   = '0;
      clr_vec  = '0;
      mode_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(ch_q) == i) begin
            sel_rd   = rd_a[i];
            sel_sum  = sum_a[i];
            sel_last = last_a[i];
            sel_mode = mode_a[i];
            if (state_q == ST_EXEC && !bad) begin
               wr_vec[i]   = (op_q == OP_WRITE);
               clr_vec[i]  = (op_q == OP_CLEAR);
               mode_vec[i] = (op_q == OP_SETMODE);
            end
         end
      end
   end

   always_comb begin
      s1_d       = inp;
      s2_d       = s1_q;
      state_d    = state_q;
      req_seen_d = req_seen_q;
      op_d       = op_q;
      ch_d       = ch_q;
      pay_d      = pay_q;
      msel_d     = msel_q;
      idx_d      = idx_q;
      max_d      = max_q;
      ack_d      = ack_q;
      busy_d     = busy_q;
      err_d      = err_q;
      res_d      = res_q;
      case (state_q)
         ST_IDLE: begin
            // HPS holds the command fields stable until ack, so s2 is safe to latch here.
            if (s2_q[IN_REQ] != req_seen_q) begin
               req_seen_d = s2_q[IN_REQ];
               op_d       = op_e'(s2_q[IN_OP_HI:IN_OP_LO]);
               ch_d       = s2_q[IN_CH_HI:IN_CH_LO];
               pay_d      = s2_q[DATA_W-1:0];
               msel_d     = s2_q[1:0];
               busy_d     = 1'b1;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!bad && op_q == OP_READ && sel_mode == MODE_PEAK) begin
               idx_d   = '0;
               max_d   = '0;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_SCAN: begin
            if (sel_rd > max_q) max_d = sel_rd;
            idx_d = idx_q + LOG2_TAPS'(1);
            if (idx_q == LOG2_TAPS'(TAPS - 1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            ack_d  = ~ack_q;
            busy_d = 1'b0;
            err_d  = bad;
            res_d  = '0;
            if (!bad) begin
               case (op_q)
                  OP_WRITE: res_d = pay_q;
                  OP_READ: begin
                     case (sel_mode)
                        MODE_AVG:    res_d = sel_sum[SUM_W-1:LOG2_TAPS];
                        MODE_BYPASS: res_d = sel_last;
                        MODE_PEAK:   res_d = max_q;
                        default:     res_d = '0;
                     endcase
                  end
                  default: res_d = '0;
               endcase
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         state_q    <= ST_IDLE;
         req_seen_q <= 1'b0;
         op_q       <= OP_WRITE;
         ch_q       <= '0;
         pay_q      <= '0;
         msel_q     <= '0;
         idx_q      <= '0;
         max_q      <= '0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         res_q      <= '0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         op_q       <= op_d;
         ch_q       <= ch_d;
         pay_q      <= pay_d;
         msel_q     <= msel_d;
         idx_q      <= idx_d;
         max_q      <= max_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         res_q      <= res_d;
      end
   end

   always_comb begin
      outp               = '0;
      outp[OUT_ACK]      = ack_q;
      outp[OUT_BUSY]     = busy_q;
      outp[OUT_ERR]      = err_q;
      outp[DATA_W-1:0]   = res_q;
   end

   assign unused_bits = ^{s2_q[28], s2_q[23:DATA_W], sel_sum[LOG2_TAPS-1:0]};

endmodule
